prog_mem_loader: RTL
====================

Name: prog_mem_loader

Overview:
- Parametrised, loadable successor to the fixed instruction ROM.
- Holds the CPU program in a RAM array that a byte-serial bootloader port fills after reset. It then serves instruction fetches to the CPU with the same negedge-registered read timing as the fixed ROM.
- Sits between the boot/UART byte source and the CPU fetch stage. It replaces the hard-coded case table.

Parameters:
- DATA_WIDTH, 16, instruction word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, fetch address width.
- DEPTH, 256, number of words implemented; DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state changes on posedge except the data output register.
- reset  input  1  synchronous, active-high reset, sampled on posedge clk.
- addr  input  ADDR_WIDTH  fetch address (program counter).
- data  output  DATA_WIDTH  fetched instruction, registered on negedge clk.
- ld_start  input  1  request a reload; honoured only in RUN.
- ld_valid  input  1  ld_byte is valid this cycle.
- ld_byte  input  8  program byte, least-significant byte of each word first.
- ld_last  input  1  qualifies ld_valid: this is the final byte of the program.
- ld_ready  output  1  the loader accepts a byte this cycle.
- busy  output  1  high while in LOAD; the CPU must be held in stall/reset while high.
- word_count  output  ADDR_WIDTH+1  number of words loaded in the last or current load.
- ovf  output  1  sticky flag: a load hit DEPTH without ld_last.

Behaviour:
- Define BYTES = DATA_WIDTH/8. Byte handshake: a byte transfers on a posedge where ld_valid && ld_ready.
- State machine, two states:
  - LOAD: ld_ready=1, busy=1.
  - RUN: ld_ready=0, busy=0.
- Reset:
  - state=LOAD, word_count=0, byte index=0, assembly register=0, ovf=0.
  - data=0 at the first negedge with reset high.
  - Memory array contents are not cleared.
- LOAD, word assembly:
  - Each accepted byte goes into lane [8*idx +: 8] of the assembly register; idx increments.
  - When idx reaches BYTES-1 on an accepted byte, the full word (including that byte) is written to mem[word_count] on the same posedge. word_count increments, and idx and the assembly register clear.
- ld_last on an accepted byte:
  - Lanes not yet filled are written as 0.
  - The word is written, word_count increments, and state goes to RUN on the same edge.
  - ld_last on byte lane 0 therefore still produces one word.
- Overflow:
  - If a word write makes word_count == DEPTH without ld_last, state goes to RUN and ovf is set.
  - Further bytes are not accepted because ld_ready=0.
- Empty load: not possible. The first accepted byte always starts a word.
- RUN:
  - ld_valid and ld_last are ignored.
  - ld_start=1 on a posedge: state goes to LOAD, word_count=0, idx=0, ovf=0. Old memory contents are retained until overwritten.
- Read path:
  - Combinational lookup: value = mem[addr] if state==RUN and addr < word_count; otherwise 0 (NOP).
  - data <= value on every negedge clk, giving a half-cycle fetch latency as with the fixed ROM.
  - Addresses >= DEPTH, or beyond the loaded length, read 0.
- Simultaneous events:
  - reset has priority over everything.
  - A word write and a read of the same address in the same cycle cannot occur, because reads return 0 in LOAD.
- Reset mid-load: any partial word is discarded and the load restarts at word 0.

Test Plan:
- Reset, then bytes 05,E0,1F,E0 with ld_last on the 4th -> mem[0]=16'hE005, mem[1]=16'hE01F, word_count=2, busy falls on that edge. addr=1 gives data=16'hE01F after the next negedge; addr=2 gives 0.
- Odd byte count: bytes 0F,93,4F with ld_last on 4F -> mem[1]=16'h004F, word_count=2.
- Fetch while busy: addr=0 during LOAD -> data=0. After load completes -> data=mem[0] from the next negedge.
- DEPTH=4, send 10 bytes with no ld_last -> RUN after byte 8, ovf=1, word_count=4, ld_ready=0, bytes 9-10 ignored.
- In RUN, pulse ld_start, load 2 bytes AA,55 with ld_last -> mem[0]=16'h55AA, word_count=1, ovf=0. addr=1 reads 0 even though the old word is retained.
- Assert reset after 3 bytes of a load -> word_count=0, busy=1, data=0. A fresh 2-byte load writes word 0 correctly with no leftover lanes.

Source files
------------

// File: rtl/prog_mem_loader.sv
// Loadable program memory: a byte-serial boot port fills a RAM after reset,
// then instruction fetches are served with a negedge-registered read.
module prog_mem_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  ovf
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] WC_ONE   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   asm_q, asm_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    wr_en;
    logic [MEM_AW-1:0]       wr_idx;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic [ADDR_WIDTH:0]     wc_inc;

    assign wc_inc = word_count_q + WC_ONE;
    assign wr_idx = word_count_q[MEM_AW-1:0];

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        ovf_d        = ovf_q;
        wr_en        = 1'b0;
        wr_word      = asm_q;
        for (int i = 0; i < BYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                wr_word[8*i +: 8] = ld_byte;
            end
        end
        case (state_q)
            ST_LOAD: begin
                if (ld_valid) begin
                    if (ld_last || idx_q == IDX_LAST) begin
                        wr_en        = 1'b1;
                        word_count_d = wc_inc;
                        idx_d        = '0;
                        asm_d        = '0;
                        if (ld_last) begin
                            state_d = ST_RUN;
                        end else if (wc_inc == DEPTH_W) begin
                            state_d = ST_RUN;
                            ovf_d   = 1'b1;
                        end
                    end else begin
                        asm_d = wr_word;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (ld_start) begin
                    state_d      = ST_LOAD;
                    word_count_d = '0;
                    idx_d        = '0;
                    asm_d        = '0;
                    ovf_d        = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Reads return NOP while loading, so a same-cycle write/read never collides.
    always_comb begin
        data_d = '0;
        if (state_q == ST_RUN && {1'b0, addr} < word_count_q) begin
            data_d = mem_q[addr[MEM_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            word_count_q <= '0;
            idx_q        <= '0;
            asm_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            ovf_q        <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data       = data_q;
    assign ld_ready   = (state_q == ST_LOAD);
    assign busy       = (state_q == ST_LOAD);
    assign word_count = word_count_q;
    assign ovf        = ovf_q;

endmodule
